// File: rtl/booth_multiplier_seq_if.sv
// Handshake and result bundle for the sequential Booth multiplier.
// The master drives the request side; the slave (the multiplier) returns status and result.
interface booth_multiplier_seq_if #(
  parameter int WIDTH = 8
);
  logic                   start;
  logic                   signed_mode;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;
  logic                   negative;

  modport master (
    output start, signed_mode, multiplicand, multiplier,
    input  busy, done, product, negative
  );

  modport slave (
    input  start, signed_mode, multiplicand, multiplier,
    output busy, done, product, negative
  );
endinterface

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier: one add/sub + arithmetic shift per cycle over WIDTH+1
// iterations, signed or unsigned operands, start/done handshake and a registered product.
module booth_multiplier_seq #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  booth_multiplier_seq_if.slave bus
);
  localparam int OW    = WIDTH + 1;
  localparam int AW    = WIDTH + 2;
  localparam int CNT_W = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [OW-1:0]      m_q, m_d;
  logic [OW-1:0]      q_q, q_d;
  logic [AW-1:0]      a_q, a_d;
  logic               q_prev_q, q_prev_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               signed_q, signed_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               negative_q, negative_d;

  logic [OW-1:0]      m_ext;
  logic [OW-1:0]      q_ext;
  logic [AW-1:0]      m_wide;
  logic [AW-1:0]      a_sum;
  logic [AW+OW:0]     shifted;
  logic               accept;

  // Extending to WIDTH+1 bits lets one signed datapath serve unsigned operands too.
  assign m_ext  = {bus.signed_mode & bus.multiplicand[WIDTH-1], bus.multiplicand};
  assign q_ext  = {bus.signed_mode & bus.multiplier[WIDTH-1], bus.multiplier};
  assign m_wide = {m_q[OW-1], m_q};
  assign accept = bus.start && (state_q == IDLE || state_q == DONE);

  always_comb begin
    a_sum = a_q;
    case ({q_q[0], q_prev_q})
      2'b01:   a_sum = a_q + m_wide;
      2'b10:   a_sum = a_q - m_wide;
      default: a_sum = a_q;
    endcase
  end

  // {A, Q, q_prev} shifted right with A's sign replicated; q_prev falls off the bottom.
  assign shifted = {a_sum[AW-1], a_sum, q_q};

  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    q_d        = q_q;
    a_d        = a_q;
    q_prev_d   = q_prev_q;
    cnt_d      = cnt_q;
    signed_d   = signed_q;
    product_d  = product_q;
    negative_d = negative_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          state_d  = RUN;
          m_d      = m_ext;
          q_d      = q_ext;
          a_d      = '0;
          q_prev_d = 1'b0;
          cnt_d    = CNT_W'(WIDTH + 1);
          signed_d = bus.signed_mode;
        end
      end
      RUN: begin
        a_d      = shifted[AW+OW:OW+1];
        q_d      = shifted[OW:1];
        q_prev_d = shifted[0];
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = DONE;
          product_d  = shifted[2*WIDTH:1];
          negative_d = signed_q & shifted[2*WIDTH];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      m_q        <= '0;
      q_q        <= '0;
      a_q        <= '0;
      q_prev_q   <= 1'b0;
      cnt_q      <= '0;
      signed_q   <= 1'b0;
      product_q  <= '0;
      negative_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      q_q        <= q_d;
      a_q        <= a_d;
      q_prev_q   <= q_prev_d;
      cnt_q      <= cnt_d;
      signed_q   <= signed_d;
      product_q  <= product_d;
      negative_q <= negative_d;
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.product  = product_q;
  assign bus.negative = negative_q;
endmodule

// File: doc/booth_multiplier_seq.md
# booth_multiplier_seq

Parametrised sequential radix-2 Booth multiplier with an integrated control FSM. It accepts two WIDTH-bit operands in signed or unsigned mode under a start/done handshake and returns a registered 2·WIDTH-bit product. It replaces the externally sequenced multiplier datapath: the add, subtract and shift decisions are made internally, so the surrounding design drives only `start` and reads the result.

## Interface
- `WIDTH`, default 8: operand width in bits, minimum 2; the product is 2·WIDTH bits.
- `clk` input 1: single clock, all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: operation request, sampled on a rising edge only in IDLE or DONE.
- `signed_mode` input 1: 1 means two's-complement operands, 0 means unsigned; captured with the operands.
- `multiplicand` input WIDTH: operand M, captured on the accepting edge.
- `multiplier` input WIDTH: operand Q, captured on the accepting edge.
- `busy` output 1: high while iterating (RUN state).
- `done` output 1: one-cycle pulse when `product` is updated.
- `product` output 2·WIDTH: registered result, held until the next completion.
- `negative` output 1: registered; 1 iff `signed_mode` was 1 and the result is below zero.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `start`=1 accepts the operation and moves to RUN; otherwise the FSM stays in IDLE.
- RUN: performs one Booth iteration per cycle for exactly WIDTH+1 cycles, then moves to DONE.
- DONE: `start`=1 accepts a new operation and moves to RUN; otherwise the FSM moves to IDLE.
- On the accepting edge:
  - Both operands are extended to WIDTH+1 bits: sign-extended if `signed_mode`=1, zero-extended if 0.
  - M is loaded with the extended multiplicand.
  - Q is loaded with the extended multiplier.
  - Accumulator A (WIDTH+2 bits) is cleared, `q_prev` is cleared, and the iteration counter is set to WIDTH+1.
- Each RUN iteration, decoded on {Q[0], q_prev}:
  - 01: A = A + M.
  - 10: A = A − M.
  - 00 and 11: no change.
  - Then {A, Q, q_prev} is arithmetic-shifted right by 1, replicating the MSB of A.
  - The counter is decremented.
- All arithmetic is modulo the A width. With WIDTH+1-bit operands and a WIDTH+2-bit accumulator there is no overflow for any operand pair in either mode.
- On entry to DONE:
  - `product` is loaded with the low 2·WIDTH bits of {A, Q}.
  - `negative` is loaded with `signed_mode` AND product MSB.
- `product` and `negative` change only on entry to DONE or on reset. They stay stable while a following operation runs.
- `start` in RUN is ignored. Operand and mode changes in RUN have no effect.
- Reset in any state, including mid-RUN:
  - Next state is IDLE and the in-flight operation is discarded.
  - `busy`, `done`, `negative` = 0 and `product` = 0.
  - Internal registers are cleared.
- `rst` and `start` on the same edge: reset wins and nothing is accepted.

## Timing
- Accepting edge is t0. RUN is visible after t0 and `busy`=1 from then on.
- Iterations occur on edges t1 … t(WIDTH+1).
- After edge t(WIDTH+1): state is DONE, `busy`=0, `done`=1, and `product` and `negative` are valid.
- Latency from the accepting edge to a visible `done` is WIDTH+1 cycles (9 for WIDTH=8).
- `done` is high for exactly one cycle.
- With `start` held high, back-to-back throughput is one result every WIDTH+2 cycles, with no IDLE cycle between operations.
- `done` and `busy` are never high in the same cycle.

## Test plan
- Reset and accept: assert `rst` for 2 cycles -> `product`=0x0000, `busy`=0, `done`=0, `negative`=0. Then with WIDTH=8, signed, 7 × −3 (0x07, 0xFD) -> `done` 9 cycles after the accepting edge, `product`=0xFFEB, `negative`=1.
- Extremes, WIDTH=8:
  - Signed −128 × −128 -> `product`=0x4000, `negative`=0.
  - Signed −128 × 127 -> `product`=0xC080, `negative`=1.
  - Unsigned 255 × 255 -> `product`=0xFE01, `negative`=0.
  - Signed 0x00 × 0xFF -> `product`=0x0000.
- Handshake: pulse `start` again and change operands while `busy`=1 -> the first result is unaffected, no extra `done` occurs, and `busy` stays high for exactly 9 cycles.
- Back-to-back: hold `start`=1 with new operands presented in each DONE cycle -> `done` pulses every 10 cycles (WIDTH=8), each `product` correct, `busy` low only during DONE cycles.
- Reset mid-operation: assert `rst` at iteration 4 -> next cycle IDLE, all outputs 0, no `done`. A fresh 12 × 12 unsigned operation then yields 0x0090.
- Random regression: WIDTH in {2, 8, 16} with random operands in both modes -> `product` equals the reference M×Q truncated to 2·WIDTH bits, latency is always WIDTH+1, and `done` is exactly one cycle wide.
